param_binary_counter: RTL and testbench
=======================================

# param_binary_counter

Parametrised up/down binary counter: the next generation of the team's fixed-width free-running counter. It adds configurable width and modulo, direction control, synchronous clear and load, wrap or saturate mode, an enable prescaler, terminal/overflow flags and an optional compare output. It is used as the general-purpose event/timebase counter inside datapath and control blocks.

## Interface
- WIDTH, 6: counter width in bits; legal range 2..32.
- MODULO, 2**WIDTH: count range 0..MODULO-1; legal range 2..2**WIDTH.
- PRESCALE, 1: number of enabled cycles per count step; legal range 1..256.

- clock  in  1  sole clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous clear of count, prescaler and overflow.
- enable  in  1  count-step qualifier.
- load  in  1  synchronous load of load_value.
- load_value  in  WIDTH  value to load.
- up_down  in  1  1 = count up, 0 = count down.
- sat_mode  in  1  1 = saturate at bounds, 0 = wrap.
- compare_value  in  WIDTH  match reference (used only with BINARY_COUNTER_COMPARE_EN).
- count  out  WIDTH  registered counter value.
- terminal  out  1  registered one-cycle pulse on wrap or blocked step.
- overflow  out  1  sticky flag: a terminal event has occurred since the last clear/reset.
- match  out  1  count == compare_value.

## Operation
- Priority per rising edge: clear > load > enable step > hold.
- clear: count <= 0, prescaler <= 0, overflow <= 0, terminal <= 0.
- load: count <= min(load_value, MODULO-1); prescaler <= 0; terminal <= 0; overflow unchanged.
- Prescaler: WIDTH-independent counter, 0..PRESCALE-1, advances only when enable=1. A step occurs on the enabled cycle in which prescaler == PRESCALE-1; prescaler then returns to 0. With PRESCALE=1 every enabled cycle is a step.
- Step, up: count < MODULO-1 -> count+1. At MODULO-1: wrap mode -> 0; saturate mode -> hold at MODULO-1.
- Step, down: count > 0 -> count-1. At 0: wrap mode -> MODULO-1; saturate mode -> hold at 0.
- Terminal event = a wrap or a saturation-blocked step. terminal is 1 for exactly the cycle after the event edge; overflow sets on the same edge as terminal and holds until clear or reset.
- Arithmetic in WIDTH+1 bits internally; no result may exceed MODULO-1 or underflow below 0.
- up_down and sat_mode are sampled only on step edges; changing them between steps has no other effect.
- enable=0: count and prescaler hold; terminal returns to 0.

## Timing
- Reset (asynchronous, immediate): count=0, prescaler=0, terminal=0, overflow=0, match = (compare_value==0) when compare enabled, else 0.
- Deassertion of reset takes effect at the next rising edge; first step no earlier than that edge.
- count latency: 1 cycle from the sampled step/load/clear edge.
- terminal: asserted on the same edge count wraps/blocks; high exactly one cycle unless another terminal event occurs on the following step.
- match: combinational from registered count and compare_value; no extra latency.
- clear or load in the same cycle as a would-be terminal step: clear/load wins, no terminal, no overflow set.
- Continuous saturation with enable held high: terminal pulses on every step attempt (each PRESCALE cycles), i.e. held high when PRESCALE=1.

## Configuration
- Macro BINARY_COUNTER_COMPARE_EN.
- Defined: match = (count == compare_value), full WIDTH compare.
- Undefined: compare logic not built; compare_value port present but ignored; match tied to 0.

## Test plan
- Reset mid-count: WIDTH=6, count at 23, assert reset between edges -> count=0, terminal=0, overflow=0 immediately; holds 0 while reset high.
- Wrap up: MODULO=10, up, wrap, enable held, start 0 -> count 0..9,0 over 10 steps; terminal high one cycle as count returns to 0; overflow=1 thereafter.
- Saturate down: MODULO=10, load 2, down, sat_mode=1 -> 1, 0, 0, 0; terminal high on each blocked step; count never 9.
- Prescaler: PRESCALE=4, enable held 12 cycles from 0 -> count steps to 3, changing every 4th cycle; enable low for 2 cycles mid-period extends that period by 2.
- Priority: load=1 with load_value=15 and MODULO=10 plus clear=1 -> count=0; next edge load only -> count=9; load and a wrap step together -> count=9, no terminal.
- Compare (macro defined): compare_value=5, count up from 3 -> match high only while count=5; macro undefined -> match stays 0.

Source files
------------

// File: rtl/param_binary_counter.sv
// param_binary_counter: up/down counter with prescaler, wrap/saturate modes and terminal/overflow flags.
// Define BINARY_COUNTER_COMPARE_EN to build the count == compare_value_i match output.
module param_binary_counter #(
    parameter int     WIDTH    = 6,
    parameter longint MODULO   = longint'(1) << WIDTH,
    parameter int     PRESCALE = 1
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             clear_i,
    input  logic             enable_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_value_i,
    input  logic             up_down_i,
    input  logic             sat_mode_i,
    input  logic [WIDTH-1:0] compare_value_i,
    output logic [WIDTH-1:0] count_o,
    output logic             terminal_o,
    output logic             overflow_o,
    output logic             match_o
);
    localparam int W1 = WIDTH + 1;
    localparam logic [WIDTH:0] MAX = W1'(MODULO - 1);
    localparam logic [7:0] PS_MAX = 8'(PRESCALE - 1);

    logic [WIDTH-1:0] count_q, count_d;
    logic [7:0] presc_q, presc_d;
    logic terminal_q, terminal_d, overflow_q, overflow_d;
    logic [WIDTH:0] cnt_ext, load_ext, step_val;
    logic step, at_top, at_bot, hit;

    always_comb begin
        cnt_ext = {1'b0, count_q};
        load_ext = {1'b0, load_value_i};
        step = enable_i && (presc_q == PS_MAX);
        at_top = cnt_ext >= MAX;
        at_bot = cnt_ext == '0;
        hit = up_down_i ? at_top : at_bot;
        step_val = up_down_i ? (at_top ? (sat_mode_i ? MAX : '0) : cnt_ext + W1'(1))
                             : (at_bot ? (sat_mode_i ? '0 : MAX) : cnt_ext - W1'(1));
        count_d = clear_i ? '0
                : load_i ? WIDTH'(load_ext > MAX ? MAX : load_ext)
                : step ? WIDTH'(step_val) : count_q;
        presc_d = (clear_i || load_i) ? '0 : enable_i ? (step ? '0 : presc_q + 8'd1) : presc_q;
        terminal_d = !clear_i && !load_i && step && hit;
        overflow_d = !clear_i && (overflow_q || terminal_d);
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            count_q <= '0;
            presc_q <= '0;
            terminal_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            count_q <= count_d;
            presc_q <= presc_d;
            terminal_q <= terminal_d;
            overflow_q <= overflow_d;
        end
    end

    assign count_o = count_q;
    assign terminal_o = terminal_q;
    assign overflow_o = overflow_q;
`ifdef BINARY_COUNTER_COMPARE_EN
    assign match_o = count_q == compare_value_i;
`else
    logic unused_cmp;
    assign unused_cmp = ^compare_value_i;
    assign match_o = 1'b0;
`endif
endmodule

// File: tb/tb_param_binary_counter.sv
// tb_param_binary_counter: two counter configurations driven by shared stimulus, checked against a behavioural model.
module tb_param_binary_counter;
    localparam int MOD [2] = '{10, 64};
    localparam int PRE [2] = '{1, 4};

    logic clk = 1'b0, rst = 1'b1, clr = 1'b0, en = 1'b0, ld = 1'b0, ud = 1'b1, sat = 1'b0;
    logic [5:0] lv = '0, cmp = '0;
    logic [5:0] cnt [2];
    logic term [2], ovf [2], mat [2];

    int mc [2], mp [2], nxt;
    bit mt [2], mo [2];
    int vectors = 0, miscompares = 0;

    always #5 clk = ~clk;

    param_binary_counter #(.WIDTH(6), .MODULO(10), .PRESCALE(1)) u1 (
        .clock_i(clk), .reset_i(rst), .clear_i(clr), .enable_i(en), .load_i(ld),
        .load_value_i(lv), .up_down_i(ud), .sat_mode_i(sat), .compare_value_i(cmp),
        .count_o(cnt[0]), .terminal_o(term[0]), .overflow_o(ovf[0]), .match_o(mat[0])
    );
    param_binary_counter #(.WIDTH(6), .MODULO(64), .PRESCALE(4)) u2 (
        .clock_i(clk), .reset_i(rst), .clear_i(clr), .enable_i(en), .load_i(ld),
        .load_value_i(lv), .up_down_i(ud), .sat_mode_i(sat), .compare_value_i(cmp),
        .count_o(cnt[1]), .terminal_o(term[1]), .overflow_o(ovf[1]), .match_o(mat[1])
    );

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic exp_match(int c);
`ifdef BINARY_COUNTER_COMPARE_EN
        return c == int'(cmp);
`else
        return (c < 0);
`endif
    endfunction

    // Model: a step moves the count by +/-1; leaving 0..MOD-1 is the terminal event.
    always @(posedge clk or posedge rst) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                mc[i] = 0; mp[i] = 0; mt[i] = 0; mo[i] = 0;
            end else if (clr) begin
                mc[i] = 0; mp[i] = 0; mt[i] = 0; mo[i] = 0;
            end else if (ld) begin
                mc[i] = (int'(lv) > MOD[i] - 1) ? MOD[i] - 1 : int'(lv);
                mp[i] = 0; mt[i] = 0;
            end else begin
                mt[i] = 0;
                if (en && mp[i] == PRE[i] - 1) begin
                    mp[i] = 0;
                    nxt = mc[i] + (ud ? 1 : -1);
                    if (nxt < 0 || nxt >= MOD[i]) begin
                        mt[i] = 1; mo[i] = 1;
                        nxt = sat ? mc[i] : (nxt + MOD[i]) % MOD[i];
                    end
                    mc[i] = nxt;
                end else if (en) begin
                    mp[i]++;
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("count[%0d]", i), 32'(cnt[i]), 32'(mc[i]));
            chk($sformatf("terminal[%0d]", i), 32'(term[i]), 32'(mt[i]));
            chk($sformatf("overflow[%0d]", i), 32'(ovf[i]), 32'(mo[i]));
            chk($sformatf("match[%0d]", i), 32'(mat[i]), 32'(exp_match(mc[i])));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2;
        chk("rst_count", 32'(cnt[0]), 0);
        chk("rst_ovf", 32'(ovf[0]), 0);
        tick(); tick();
        rst = 1'b0;
        en = 1'b1; ud = 1'b1; sat = 1'b0;
        repeat (9) tick();
        chk("wrap_9", 32'(cnt[0]), 9);
        chk("wrap_9_term", 32'(term[0]), 0);
        chk("presc_9", 32'(cnt[1]), 2);
        tick();
        chk("wrap_0", 32'(cnt[0]), 0);
        chk("wrap_term", 32'(term[0]), 1);
        chk("wrap_ovf", 32'(ovf[0]), 1);
        tick();
        chk("wrap_term_drop", 32'(term[0]), 0);
        tick();
        chk("wrap_2", 32'(cnt[0]), 2);
        chk("presc_12", 32'(cnt[1]), 3);
        chk("ovf_sticky", 32'(ovf[0]), 1);
        clr = 1'b1; en = 1'b0;
        tick();
        chk("clear_ovf", 32'(ovf[0]), 0);
        clr = 1'b0; en = 1'b1;
        tick(); tick();
        en = 1'b0;
        tick(); tick();
        en = 1'b1;
        tick();
        chk("presc_gap_hold", 32'(cnt[1]), 0);
        tick();
        chk("presc_gap_step", 32'(cnt[1]), 1);
        en = 1'b0; ld = 1'b1; lv = 6'd2;
        tick();
        chk("load_2", 32'(cnt[0]), 2);
        ld = 1'b0; en = 1'b1; ud = 1'b0; sat = 1'b1;
        tick();
        chk("sat_1", 32'(cnt[0]), 1);
        tick();
        chk("sat_0", 32'(cnt[0]), 0);
        chk("sat_0_term", 32'(term[0]), 0);
        tick();
        chk("sat_block", 32'(cnt[0]), 0);
        chk("sat_block_term", 32'(term[0]), 1);
        tick();
        chk("sat_block2_term", 32'(term[0]), 1);
        clr = 1'b1; ld = 1'b1; lv = 6'd15;
        tick();
        chk("prio_clear", 32'(cnt[0]), 0);
        clr = 1'b0;
        tick();
        chk("prio_load_clamp", 32'(cnt[0]), 9);
        chk("prio_load_full", 32'(cnt[1]), 15);
        ud = 1'b1; sat = 1'b0;
        tick();
        chk("prio_load_wrap", 32'(cnt[0]), 9);
        chk("prio_no_term", 32'(term[0]), 0);
        chk("prio_no_ovf", 32'(ovf[0]), 0);
        en = 1'b0; lv = 6'd3; cmp = 6'd5;
        tick();
        ld = 1'b0; en = 1'b1;
        chk("cmp_3", 32'(mat[0]), 0);
        tick(); tick();
`ifdef BINARY_COUNTER_COMPARE_EN
        chk("cmp_5", 32'(mat[0]), 1);
`else
        chk("cmp_5", 32'(mat[0]), 0);
`endif
        tick();
        chk("cmp_6", 32'(mat[0]), 0);
        repeat (3000) begin
            clr = ($urandom_range(0, 31) == 0);
            ld = ($urandom_range(0, 15) == 0);
            en = ($urandom_range(0, 3) != 0);
            ud = 1'($urandom);
            sat = 1'($urandom);
            lv = 6'($urandom_range(0, 63));
            cmp = 6'($urandom_range(0, 15));
            tick();
        end
        clr = 1'b0; ld = 1'b1; lv = 6'd23; en = 1'b0; ud = 1'b1; sat = 1'b0;
        tick();
        ld = 1'b0;
        chk("mid_load_23", 32'(cnt[1]), 23);
        en = 1'b1;
        #3 rst = 1'b1;
        #1;
        chk("mid_rst_count", 32'(cnt[1]), 0);
        chk("mid_rst_term", 32'(term[1]), 0);
        chk("mid_rst_ovf", 32'(ovf[0]), 0);
        tick(); tick();
        chk("rst_hold", 32'(cnt[0]), 0);
        rst = 1'b0;
        tick();
        chk("rst_release_step", 32'(cnt[0]), 1);
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
